mem_io_responder: RTL
=====================

Name: mem_io_responder

Overview:
- Memory-side responder for the CPU's byte-wide memory bus.
- Serves 128 KB of RAM plus the memory-mapped I/O page (mem_a[17:16] == 2'b11): UART byte input, UART byte output, cycle clock and program stop.
- Drives the CPU's rdy line to stall it when a UART write cannot be accepted.
- Byte streams to and from the UART use valid/ready handshakes through internal FIFOs.

Parameters:
- RAM_ADDR_W, 17: RAM address width; RAM holds 2^RAM_ADDR_W bytes.
- TX_DEPTH_LOG2, 3: TX FIFO depth is 2^TX_DEPTH_LOG2 entries.
- RX_DEPTH_LOG2, 3: RX FIFO depth is 2^RX_DEPTH_LOG2 entries.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset.
- cpu_a  input  32  address from CPU; only bits 17:0 are decoded.
- cpu_wr  input  1  1 = write, 0 = read.
- cpu_dout  input  8  write data from CPU.
- cpu_din  output  8  read data to CPU.
- rdy_out  output  1  CPU ready; low stalls the CPU.
- rx_valid  input  1  UART RX byte available.
- rx_data  input  8  UART RX byte.
- rx_ready  output  1  RX FIFO can accept a byte.
- tx_valid  output  1  TX FIFO non-empty.
- tx_data  output  8  TX FIFO head byte.
- tx_ready  input  1  UART accepts a TX byte.
- prog_stop  output  1  sticky; program has signalled stop.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: cpu_din = 0x00; both FIFOs empty; tx_valid = 0; rx_ready = 1; prog_stop = 0; cycle counter = 0; snapshot = 0.
  - RAM contents are not reset.
  - Reset asserted mid-operation discards queued FIFO data immediately.
- Request handling: a request is accepted at a rising edge only when rdy_out = 1. While rdy_out = 0, no state other than the FIFO UART-side ports and the counter changes, and cpu_din holds.
- Read latency: read data for the address accepted at edge N appears on cpu_din after edge N and stays until the next accepted read.
- Write latency: 1 cycle. Write takes effect at the accepting edge.
- Decode:
  - mem_a[17:16] != 2'b11 selects RAM, index = cpu_a[RAM_ADDR_W-1:0]. Addresses at or above 0x20000 wrap by this mask.
  - Otherwise I/O, decoded on cpu_a[2:0] within the page; the remaining page bits are ignored.
- I/O map:
  - 0x30000 read: pop the RX FIFO head into cpu_din. If empty, return 0x00 with no pop.
  - 0x30000 write: if cpu_dout != 0x00, push to the TX FIFO. A write of 0x00 is ignored (no push, no stall).
  - 0x30004..0x30007 read: return bytes 0..3 of the cycle clock, little-endian.
    - A read of 0x30004 returns counter[7:0] and loads the snapshot with the full counter in the same edge.
    - 0x30005..0x30007 return snapshot bytes 1..3.
  - 0x30004 write: push 0x00 to the TX FIFO and set prog_stop = 1 (sticky until reset). The written value is ignored.
  - Any other I/O offset: read returns 0x00; write ignored.
- Stall: rdy_out = 0 combinationally when the current request is a TX push (0x30000 nonzero write, or a 0x30004 write) and the TX FIFO is full. Otherwise rdy_out = 1. A pop in the same cycle does not release the stall; release occurs the cycle after count < depth.
- Cycle counter:
  - 32-bit.
  - Increments every clock after reset, independent of rdy_out.
  - Wraps 0xFFFFFFFF -> 0.
- TX FIFO:
  - tx_valid = !empty; tx_data = head.
  - Pop when tx_valid && tx_ready.
  - Push and pop in the same cycle: count unchanged, data order preserved.
- RX FIFO:
  - rx_ready = !full.
  - Push when rx_valid && rx_ready.
  - Simultaneous push and CPU pop on a non-empty FIFO: count unchanged.
  - Push while empty coincident with a CPU read: read returns 0x00 and the pushed byte is retained.
- FIFO pointers: TX and RX pointers are binary and wrap modulo depth; an extra bit distinguishes full from empty.

Test Plan:
- RAM write/read: write 0xA5 to 0x00123, then read 0x00123 -> cpu_din = 0xA5 one cycle after acceptance. Read 0x20123 -> 0xA5 (wrap).
- UART out: write 0x48, 0x00, 0x69 to 0x30000 with tx_ready = 1 -> tx_data sequence 0x48, 0x69 only. Write to 0x30004 -> a further 0x00 byte; prog_stop = 1 and stays 1.
- TX stall: tx_ready = 0, nine nonzero writes to 0x30000 (depth 8) -> rdy_out = 0 on the ninth. Raise tx_ready one cycle -> rdy_out = 1 next cycle, ninth byte queued, order intact.
- UART in: push 0x31, 0x32 via rx_valid -> two reads of 0x30000 return 0x31, 0x32. A third read returns 0x00. RX full -> rx_ready = 0.
- Clock read: 1000 cycles after reset, read 0x30004..0x30007 -> bytes reconstruct the value at the 0x30004 read (bytes 1..3 from snapshot, not live). Preload the counter near 0xFFFFFFFF -> wrap to 0.
- Reset mid-operation: assert rst_in low with a non-empty TX FIFO and prog_stop = 1 -> tx_valid, prog_stop, cpu_din and counter clear immediately (asynchronously).

Source files
------------

// File: rtl/mem_io_responder_if.sv
// CPU byte-bus and UART byte-stream signals of the memory/I-O responder.
// The slave modport is the responder; the master modport is the CPU/UART side.
interface mem_io_responder_if;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        rdy_out;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        prog_stop;

    modport slave (
        input  cpu_a, cpu_wr, cpu_dout, rx_valid, rx_data, tx_ready,
        output cpu_din, rdy_out, rx_ready, tx_valid, tx_data, prog_stop
    );

    modport master (
        output cpu_a, cpu_wr, cpu_dout, rx_valid, rx_data, tx_ready,
        input  cpu_din, rdy_out, rx_ready, tx_valid, tx_data, prog_stop
    );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder: RAM plus an I/O page with UART RX/TX FIFOs, a cycle
// clock with byte snapshot, and a sticky program-stop flag.
module mem_io_responder #(
    parameter int          RAM_ADDR_W    = 17,
    parameter int          TX_DEPTH_LOG2 = 3,
    parameter int          RX_DEPTH_LOG2 = 3,
    // Value the cycle counter takes on reset; nonzero only to exercise wrap.
    parameter logic [31:0] CNT_INIT      = 32'h0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    mem_io_responder_if.slave bus
);
    localparam int TX_PW = TX_DEPTH_LOG2 + 1;
    localparam int RX_PW = RX_DEPTH_LOG2 + 1;
    localparam logic [TX_PW-1:0] TX_FULL_X = {1'b1, {TX_DEPTH_LOG2{1'b0}}};
    localparam logic [RX_PW-1:0] RX_FULL_X = {1'b1, {RX_DEPTH_LOG2{1'b0}}};

    logic [7:0] ram    [0:(1<<RAM_ADDR_W)-1];
    logic [7:0] tx_mem [0:(1<<TX_DEPTH_LOG2)-1];
    logic [7:0] rx_mem [0:(1<<RX_DEPTH_LOG2)-1];
    logic [7:0] ram_rdata_q;

    logic [TX_PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [RX_PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [31:0]      cnt_q, cnt_d, snap_q, snap_d;
    logic             prog_stop_q, prog_stop_d;
    logic [7:0]       io_rd_q, io_rd_d;
    logic             rd_ram_q, rd_ram_d;

    logic                  is_io, rdy;
    logic [2:0]            io_off;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic                  tx_push_req, tx_push, tx_pop, rx_push, rx_pop;
    logic                  snap_load, stop_set;
    logic [7:0]            tx_push_data, rx_head;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^bus.cpu_a[31:18];
    assign ram_idx  = bus.cpu_a[RAM_ADDR_W-1:0];
    assign tx_empty = (tx_wr_ptr_q == tx_rd_ptr_q);
    assign tx_full  = ((tx_wr_ptr_q ^ tx_rd_ptr_q) == TX_FULL_X);
    assign rx_empty = (rx_wr_ptr_q == rx_rd_ptr_q);
    assign rx_full  = ((rx_wr_ptr_q ^ rx_rd_ptr_q) == RX_FULL_X);
    assign rx_head  = rx_mem[rx_rd_ptr_q[RX_DEPTH_LOG2-1:0]];

    always_comb begin
        is_io        = (bus.cpu_a[17:16] == 2'b11);
        io_off       = bus.cpu_a[2:0];
        tx_push_req  = is_io && bus.cpu_wr &&
                       ((io_off == 3'd0 && bus.cpu_dout != 8'h00) || io_off == 3'd4);
        // Stall only on a TX push into a full FIFO; same-cycle pop does not help.
        rdy          = !(tx_push_req && tx_full);
        tx_push      = tx_push_req && rdy;
        tx_push_data = (io_off == 3'd4) ? 8'h00 : bus.cpu_dout;
        tx_pop       = !tx_empty && bus.tx_ready;
        rx_push      = bus.rx_valid && !rx_full;
        rx_pop       = rdy && is_io && !bus.cpu_wr && io_off == 3'd0 && !rx_empty;
        snap_load    = rdy && is_io && !bus.cpu_wr && io_off == 3'd4;
        stop_set     = rdy && is_io && bus.cpu_wr && io_off == 3'd4;

        tx_wr_ptr_d  = tx_wr_ptr_q + TX_PW'(tx_push);
        tx_rd_ptr_d  = tx_rd_ptr_q + TX_PW'(tx_pop);
        rx_wr_ptr_d  = rx_wr_ptr_q + RX_PW'(rx_push);
        rx_rd_ptr_d  = rx_rd_ptr_q + RX_PW'(rx_pop);
        cnt_d        = cnt_q + 32'd1;
        snap_d       = snap_load ? cnt_q : snap_q;
        prog_stop_d  = prog_stop_q || stop_set;

        io_rd_d      = io_rd_q;
        rd_ram_d     = rd_ram_q;
        if (rdy && !bus.cpu_wr) begin
            rd_ram_d = !is_io;
            if (is_io) begin
                case (io_off)
                    3'd0:    io_rd_d = rx_empty ? 8'h00 : rx_head;
                    3'd4:    io_rd_d = cnt_q[7:0];
                    3'd5:    io_rd_d = snap_q[15:8];
                    3'd6:    io_rd_d = snap_q[23:16];
                    3'd7:    io_rd_d = snap_q[31:24];
                    default: io_rd_d = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            cnt_q       <= CNT_INIT;
            snap_q      <= '0;
            prog_stop_q <= 1'b0;
            io_rd_q     <= 8'h00;
            rd_ram_q    <= 1'b0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            prog_stop_q <= prog_stop_d;
            io_rd_q     <= io_rd_d;
            rd_ram_q    <= rd_ram_d;
        end
    end

    // Storage arrays carry no reset; emptiness is defined by the pointers.
    always_ff @(posedge clk_in) begin
        if (tx_push) tx_mem[tx_wr_ptr_q[TX_DEPTH_LOG2-1:0]] <= tx_push_data;
        if (rx_push) rx_mem[rx_wr_ptr_q[RX_DEPTH_LOG2-1:0]] <= bus.rx_data;
        if (rdy && !is_io) begin
            if (bus.cpu_wr) ram[ram_idx] <= bus.cpu_dout;
            else            ram_rdata_q  <= ram[ram_idx];
        end
    end

    assign bus.cpu_din   = rd_ram_q ? ram_rdata_q : io_rd_q;
    assign bus.rdy_out   = rdy;
    assign bus.rx_ready  = !rx_full;
    assign bus.tx_valid  = !tx_empty;
    assign bus.tx_data   = tx_mem[tx_rd_ptr_q[TX_DEPTH_LOG2-1:0]];
    assign bus.prog_stop = prog_stop_q;
endmodule
